// File: rtl/alu_mdu_pipe.sv
// EX-stage ALU with iterative multiply/divide, all results registered behind a
// valid/ready handshake so the pipeline can stall on multi-cycle operations.
module alu_mdu_pipe #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CTRL_W-1:0] alucontrol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              overflow,
    output logic              div_by_zero
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [CTRL_W-1:0] OP_AND   = 4'b0000;
    localparam logic [CTRL_W-1:0] OP_OR    = 4'b0001;
    localparam logic [CTRL_W-1:0] OP_ADD   = 4'b0010;
    localparam logic [CTRL_W-1:0] OP_XOR   = 4'b0011;
    localparam logic [CTRL_W-1:0] OP_SLL   = 4'b0100;
    localparam logic [CTRL_W-1:0] OP_SRL   = 4'b0101;
    localparam logic [CTRL_W-1:0] OP_SUB   = 4'b0110;
    localparam logic [CTRL_W-1:0] OP_SLT   = 4'b0111;
    localparam logic [CTRL_W-1:0] OP_DIVU  = 4'b1010;
    localparam logic [CTRL_W-1:0] OP_REMU  = 4'b1011;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_reg;
    logic [SH_W-1:0]      cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     opd_reg;
    logic [1:0]           op_reg;

    logic                 accept;
    logic                 multi;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     sc_result;
    logic                 sc_ovf;
    logic                 sc_dbz;

    assign in_ready = (state_reg == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    // MUL/MULHU/DIVU/REMU share the 10xx prefix; divide by zero stays single-cycle
    assign multi    = (alucontrol[3:2] == 2'b10) && (b != '0);
    assign sum      = a + b;
    assign diff     = a - b;

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        sc_dbz    = 1'b0;
        case (alucontrol)
            OP_AND: sc_result = a & b;
            OP_OR:  sc_result = a | b;
            OP_XOR: sc_result = a ^ b;
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLL: sc_result = a << b[SH_W-1:0];
            OP_SRL: sc_result = a >> b[SH_W-1:0];
            OP_DIVU: begin
                sc_result = '1;
                sc_dbz    = 1'b1;
            end
            OP_REMU: begin
                sc_result = a;
                sc_dbz    = 1'b1;
            end
            default: sc_result = '0;
        endcase
    end

    // Multiply: acc = {partial, multiplier}; add multiplicand into the top half, shift right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opd_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; restoring shift-subtract.
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opd_reg};
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opd_reg}) : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_reg[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0]   iter_next;
    logic [WIDTH-1:0]     iter_result;
    assign iter_next = op_reg[1] ? div_next : mul_next;

    always_comb begin
        case (op_reg)
            2'b00:   iter_result = mul_next[WIDTH-1:0];
            2'b01:   iter_result = mul_next[2*WIDTH-1:WIDTH];
            2'b10:   iter_result = div_next[WIDTH-1:0];
            default: iter_result = div_next[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opd_reg     <= '0;
            op_reg      <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (multi) begin
                            state_reg <= BUSY;
                            cnt_reg   <= SH_W'(WIDTH - 1);
                            op_reg    <= alucontrol[1:0];
                            if (alucontrol[1]) begin
                                acc_reg <= {{WIDTH{1'b0}}, a};
                                opd_reg <= b;
                            end else begin
                                acc_reg <= {{WIDTH{1'b0}}, b};
                                opd_reg <= a;
                            end
                        end else begin
                            out_valid   <= 1'b1;
                            result      <= sc_result;
                            zero        <= (sc_result == '0);
                            overflow    <= sc_ovf;
                            div_by_zero <= sc_dbz;
                        end
                    end
                end
                BUSY: begin
                    acc_reg <= iter_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg   <= IDLE;
                        out_valid   <= 1'b1;
                        result      <= iter_result;
                        zero        <= (iter_result == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu_pipe.sv
// Directed testbench for alu_mdu_pipe (WIDTH=32): legacy ops, flags, shifts,
// multiply/divide latency, backpressure and reset during an iterative op.
module tb_alu_mdu_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alucontrol;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         div_by_zero;

    int compared   = 0;
    int mismatched = 0;

    alu_mdu_pipe #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alucontrol(alucontrol),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]   lg_op [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b0111};
    logic [W-1:0] lg_a  [7] = '{32'hA5A5A5A5, 32'h12345678, 32'd100, 32'd50, 32'd5, 32'd20, 32'hFFFFFFFB};
    logic [W-1:0] lg_b  [7] = '{32'h5A5A5A5A, 32'h87654321, 32'd23, 32'd75, 32'd10, 32'd10, 32'd3};
    logic [W-1:0] lg_r  [7] = '{32'h0, 32'h97755779, 32'd123, 32'hFFFFFFE7, 32'd1, 32'd0, 32'd1};

    logic [3:0]   ov_op [7] = '{4'b0010, 4'b0110, 4'b1111, 4'b0100, 4'b0011, 4'b0101, 4'b0010};
    logic [W-1:0] ov_a  [7] = '{32'h7FFFFFFF, 32'h80000000, 32'd123, 32'd1, 32'hF0F0F0F0, 32'h80000000, 32'hFFFFFFFF};
    logic [W-1:0] ov_b  [7] = '{32'd1, 32'd1, 32'd456, 32'd35, 32'hFF00FF00, 32'd31, 32'd1};
    logic [W-1:0] ov_r  [7] = '{32'h80000000, 32'h7FFFFFFF, 32'h0, 32'd8, 32'h0FF00FF0, 32'd1, 32'h0};
    logic         ov_f  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [3:0]   md_op [5] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1010};
    logic [W-1:0] md_a  [5] = '{32'd1234, 32'hFFFFFFFF, 32'd100, 32'd100, 32'hFFFFFFFF};
    logic [W-1:0] md_b  [5] = '{32'd5678, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd10};
    logic [W-1:0] md_r  [5] = '{32'd7006652, 32'hFFFFFFFE, 32'd14, 32'd2, 32'h19999999};

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alucontrol = '0;
        step(); step();
        reset = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b0 || overflow !== 1'b0 ||
            div_by_zero !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset: got v=%b r=%h z=%b o=%b d=%b rdy=%b required v=0 r=0 z=0 o=0 d=0 rdy=1",
                     out_valid, result, zero, overflow, div_by_zero, in_ready);
        end
        $display("reset: out_valid=%b in_ready=%b result=%h", out_valid, in_ready, result);
    endtask

    task automatic test_legacy();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; alucontrol = lg_op[i]; a = lg_a[i]; b = lg_b[i];
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL legacy_in_ready[%0d]: got %b required 1", i, in_ready);
            end
            step();
            compared++;
            if (out_valid !== 1'b1 || result !== lg_r[i] || zero !== (lg_r[i] == '0)) begin
                mismatched++;
                $display("FAIL legacy[%0d]: got v=%b r=%h z=%b required v=1 r=%h z=%b",
                         i, out_valid, result, zero, lg_r[i], lg_r[i] == '0);
            end
            $display("legacy op=%b a=%h b=%h -> %h z=%b", lg_op[i], lg_a[i], lg_b[i], result, zero);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_overflow_shift();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; alucontrol = ov_op[i]; a = ov_a[i]; b = ov_b[i];
            step();
            compared++;
            if (out_valid !== 1'b1 || result !== ov_r[i] || zero !== (ov_r[i] == '0) ||
                overflow !== ov_f[i]) begin
                mismatched++;
                $display("FAIL ovf_shift[%0d]: got v=%b r=%h z=%b o=%b required v=1 r=%h z=%b o=%b",
                         i, out_valid, result, zero, overflow, ov_r[i], ov_r[i] == '0, ov_f[i]);
            end
            $display("ovf/shift op=%b a=%h b=%h -> %h o=%b", ov_op[i], ov_a[i], ov_b[i], result, overflow);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul_div(input int first, input int last);
        out_ready = 1'b1;
        for (int i = first; i <= last; i++) begin
            in_valid = 1'b1; alucontrol = md_op[i]; a = md_a[i]; b = md_b[i];
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL mdu_in_ready[%0d]: got %b required 1", i, in_ready);
            end
            step();
            in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D;
            for (int j = 0; j < W; j++) begin
                compared++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL mdu_busy[%0d] cycle %0d: got v=%b rdy=%b required v=0 rdy=0",
                             i, j, out_valid, in_ready);
                end
                if (j < W - 1) step();
            end
            step();
            compared++;
            if (out_valid !== 1'b1 || result !== md_r[i] || zero !== 1'b0 || div_by_zero !== 1'b0) begin
                mismatched++;
                $display("FAIL mdu_result[%0d]: got v=%b r=%h z=%b d=%b required v=1 r=%h z=0 d=0",
                         i, out_valid, result, zero, div_by_zero, md_r[i]);
            end
            $display("mdu op=%b a=%h b=%h -> %h after %0d cycles", md_op[i], md_a[i], md_b[i], result, W);
        end
        step();
    endtask

    task automatic test_multiply();
        test_mul_div(0, 1);
    endtask

    task automatic test_divide();
        test_mul_div(2, 4);
    endtask

    task automatic test_div_by_zero();
        out_ready = 1'b1;
        in_valid = 1'b1; alucontrol = 4'b1010; a = 32'd9; b = 32'd0;
        step();
        compared++;
        if (out_valid !== 1'b1 || result !== 32'hFFFFFFFF || div_by_zero !== 1'b1 || zero !== 1'b0) begin
            mismatched++;
            $display("FAIL divu_by_zero: got v=%b r=%h d=%b z=%b required v=1 r=ffffffff d=1 z=0",
                     out_valid, result, div_by_zero, zero);
        end
        $display("divu 9/0 -> %h dbz=%b", result, div_by_zero);
        alucontrol = 4'b1011;
        step();
        compared++;
        if (out_valid !== 1'b1 || result !== 32'd9 || div_by_zero !== 1'b1) begin
            mismatched++;
            $display("FAIL remu_by_zero: got v=%b r=%h d=%b required v=1 r=00000009 d=1",
                     out_valid, result, div_by_zero);
        end
        $display("remu 9%%0 -> %h dbz=%b", result, div_by_zero);
        alucontrol = 4'b0010; a = 32'd1; b = 32'd1;
        step();
        compared++;
        if (result !== 32'd2 || div_by_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL dbz_clear: got r=%h d=%b required r=00000002 d=0", result, div_by_zero);
        end
        $display("add 1+1 -> %h dbz=%b", result, div_by_zero);
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; alucontrol = 4'b0010; a = 32'd5; b = 32'd6;
        step();
        alucontrol = 4'b0110; a = 32'd10; b = 32'd3;
        for (int c = 0; c < 5; c++) begin
            compared++;
            if (out_valid !== 1'b1 || result !== 32'd11 || zero !== 1'b0 || overflow !== 1'b0 ||
                in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL backpressure_hold[%0d]: got v=%b r=%h z=%b o=%b rdy=%b required v=1 r=0000000b z=0 o=0 rdy=0",
                         c, out_valid, result, zero, overflow, in_ready);
            end
            $display("stall cycle %0d: result=%h in_ready=%b", c, result, in_ready);
            step();
        end
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL backpressure_release_ready: got %b required 1", in_ready);
        end
        step();
        compared++;
        if (out_valid !== 1'b1 || result !== 32'd7) begin
            mismatched++;
            $display("FAIL backpressure_pending: got v=%b r=%h required v=1 r=00000007", out_valid, result);
        end
        $display("pending sub 10-3 -> %h", result);
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_op();
        out_ready = 1'b1;
        in_valid = 1'b1; alucontrol = 4'b1010; a = 32'hFFFFFFFF; b = 32'd3;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 21; j++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_op: got v=%b rdy=%b r=%h required v=0 rdy=1 r=0", out_valid, in_ready, result);
        end
        $display("reset mid-divide: out_valid=%b in_ready=%b", out_valid, in_ready);
        in_valid = 1'b1; alucontrol = 4'b0010; a = 32'd2; b = 32'd3;
        step();
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            mismatched++;
            $display("FAIL post_reset_add: got v=%b r=%h required v=1 r=00000005", out_valid, result);
        end
        $display("post-reset add 2+3 -> %h", result);
        step();
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_overflow_shift();
        test_multiply();
        test_divide();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_mdu_pipe.md
Name: alu_mdu_pipe

Overview:
- Parametrised successor to the pipeline's combinational 3-bit ALU.
- Keeps the legacy AND/OR/ADD/SUB/SLT encodings, adds XOR and shifts, and adds iterative multiply/divide.
- Registers all results behind a valid/ready handshake, so the EX stage can stall on multi-cycle ops.
- Sits in the EX stage between the ID/EX register and the EX/MEM register.

Parameters:
- WIDTH, 32, operand/result width; power of 2, >= 8.
- CTRL_W, 4, alucontrol width; fixed at 4, exposed for lint/bench use.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, a/b/alucontrol valid.
- in_ready, output, 1, block accepts an operation this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- alucontrol, input, CTRL_W, operation select.
- out_valid, output, 1, result/flags valid.
- out_ready, input, 1, consumer takes the result this cycle.
- result, output, WIDTH, operation result.
- zero, output, 1, result == 0.
- overflow, output, 1, signed overflow (ADD/SUB only).
- div_by_zero, output, 1, DIVU/REMU with b == 0.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; out_valid=0; result=0; zero=0; overflow=0; div_by_zero=0. in_ready is 1 in the first cycle after reset.
- Opcode table (alucontrol):
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 0111 SLT (signed, result 1/0).
  - 0011 XOR; 0100 SLL; 0101 SRL; shift amount = b[log2(WIDTH)-1:0].
  - 1000 MUL (low WIDTH bits, unsigned); 1001 MULHU (high WIDTH bits, unsigned product).
  - 1010 DIVU; 1011 REMU.
  - Any other code: result=0, all flags 0, single-cycle.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Back-to-back single-cycle ops sustain 1 op/cycle.
  - While out_valid && !out_ready: result and all flags hold stable, and in_ready=0.
- Single-cycle ops (opcodes 0xxx, illegal codes, DIVU/REMU with b==0):
  - Accepted at edge k; at edge k the result and flags are registered and out_valid=1.
  - Visible the following cycle, i.e. latency 1.
- Multi-cycle ops (MUL/MULHU/DIVU/REMU with b!=0):
  - Edge k: latch operands, state=BUSY, cnt=WIDTH-1.
  - Edges k+1..k+WIDTH: one iteration per edge.
    - MUL/MULHU: shift-add on a 2*WIDTH accumulator.
    - DIVU/REMU: restoring shift-subtract, one quotient bit per edge.
  - On the iteration with cnt==0: write result, set out_valid=1, state=IDLE. Latency = WIDTH cycles.
  - in_ready=0 throughout BUSY.
- Out_valid/accept ordering: if out_valid is set and out_ready=1 in the cycle a new op is accepted, the old result retires and the new one occupies the register per the rules above. No bubble for single-cycle ops.
- Divide by zero:
  - DIVU gives all-ones; REMU gives a.
  - div_by_zero=1; completes single-cycle.
- Flags:
  - zero = (result==0) for every op.
  - overflow (ADD) = sign(a)==sign(b) && sign(sum)!=sign(a).
  - overflow (SUB) = sign(a)!=sign(b) && sign(diff)!=sign(a).
  - Otherwise overflow=0.
- Reset mid-operation: abort the BUSY iteration, discard any held result; next cycle state=IDLE, out_valid=0.
- Ignored input: in_valid while in_ready=0 is ignored (no capture). Inputs need not be held after acceptance.

Test Plan:
- Legacy ops, WIDTH=32, out_ready=1:
  - AND A5A5A5A5,5A5A5A5A -> 00000000, zero=1.
  - OR 12345678,87654321 -> 97755779.
  - ADD 100,23 -> 123.
  - SUB 50,75 -> FFFFFFE7.
  - SLT 5,10 -> 1; SLT 20,10 -> 0; SLT FFFFFFFB,3 -> 1.
  - Each op has out_valid one cycle after accept, and a new op is accepted every cycle.
- Overflow, illegal code, shifts:
  - ADD 7FFFFFFF,1 -> 80000000, overflow=1.
  - SUB 80000000,1 -> 7FFFFFFF, overflow=1.
  - alucontrol=1111 -> result 0, zero=1, overflow=0.
  - SLL 1,35 -> 8 (amount masked to 3).
- Multiply:
  - MUL 1234,5678 -> 7006652.
  - MULHU FFFFFFFF,FFFFFFFF -> FFFFFFFE.
  - out_valid exactly 32 cycles after accept; in_ready=0 throughout.
- Divide:
  - DIVU 100,7 -> 14; REMU 100,7 -> 2, latency 32.
  - DIVU 9,0 -> FFFFFFFF, div_by_zero=1, latency 1; REMU 9,0 -> 9.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after an ADD result: result/flags stable, in_ready=0, and a pending in_valid op is not captured.
  - Raise out_ready: the pending op is accepted in that same cycle.
- Reset mid-op:
  - Assert reset for 1 cycle at cnt=10 of a DIVU.
  - Next cycle out_valid=0 and in_ready=1.
  - A following ADD 2,3 -> 5 with normal latency.
